// File: rtl/cordic_iter_ctrl.sv
// Iteration sequencer for the CORDIC z-angle accumulator: arctan ROM, iteration counter, start/done handshake.
// Optional CORDIC_VECTORING_EN adds mode/ysign inputs for vectoring-mode direction control.
module cordic_iter_ctrl #(
   parameter int unsigned ITER = 16,
   parameter int unsigned W    = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         zsign,
`ifdef CORDIC_VECTORING_EN
   input  logic         mode,
   input  logic         ysign,
`endif
   output logic         load,
   output logic         stop,
   output logic         cin,
   output logic [W-1:0] zrom,
   output logic [3:0]   shift_amt,
   output logic         busy,
   output logic         done
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] iter_q;
   logic             load_q;
   logic             stop_q;
   logic             busy_q;
   logic             done_q;
   logic             dir_c;

   // arctan(2^-i) with 1 rad = 2^13 LSB
   function automatic logic [15:0] atan_rom(input logic [CNT_W-1:0] idx);
      case (idx)
         4'd0:  atan_rom = 16'h1922;
         4'd1:  atan_rom = 16'h0ED6;
         4'd2:  atan_rom = 16'h07D7;
         4'd3:  atan_rom = 16'h03FB;
         4'd4:  atan_rom = 16'h01FF;
         4'd5:  atan_rom = 16'h0100;
         4'd6:  atan_rom = 16'h0080;
         4'd7:  atan_rom = 16'h0040;
         4'd8:  atan_rom = 16'h0020;
         4'd9:  atan_rom = 16'h0010;
         4'd10: atan_rom = 16'h0008;
         4'd11: atan_rom = 16'h0004;
         4'd12: atan_rom = 16'h0002;
         4'd13: atan_rom = 16'h0001;
         4'd14: atan_rom = 16'h0001;
         4'd15: atan_rom = 16'h0000;
      endcase
   endfunction

`ifdef CORDIC_VECTORING_EN
   logic mode_q;
   assign dir_c = mode_q ? ysign : ~zsign;
`else
   assign dir_c = ~zsign;
`endif

   // Sequencer; handshake outputs are registered alongside the state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         iter_q  <= '0;
         load_q  <= 1'b0;
         stop_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef CORDIC_VECTORING_EN
         mode_q  <= 1'b0;
`endif
      end else begin
         load_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_LOAD;
                  load_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  stop_q  <= 1'b1;
               end
            end
            S_LOAD: begin
               state_q <= S_RUN;
               iter_q  <= '0;
               stop_q  <= 1'b0;
`ifdef CORDIC_VECTORING_EN
               mode_q  <= mode;
`endif
            end
            S_RUN: begin
               if (iter_q == LAST) begin
                  state_q <= S_DONE;
                  iter_q  <= '0;
                  stop_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  iter_q <= iter_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // ROM and direction are combinational so the accumulator sees them within the same cycle
   assign zrom      = (state_q == S_RUN) ? W'(atan_rom(iter_q)) : '0;
   assign cin       = (state_q == S_RUN) & dir_c;
   assign shift_amt = iter_q;
   assign load      = load_q;
   assign stop      = stop_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
